// File: rtl/activation_cache.sv
// Dilated causal activation buffer: stores one D-element vector per timestep and presents the
// four taps t-3d, t-2d, t-d, t. Optional macro: ACTIVATION_CACHE_ZERO_PAD_EN (causal zero padding).
module activation_cache #(
  parameter int unsigned W        = 16,
  parameter int unsigned D        = 8,
  parameter int unsigned DILATION = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inp_v,
  input  logic [D*W-1:0] packed_inp,
  output logic           busy,
  output logic [D*W-1:0] packed_a0,
  output logic [D*W-1:0] packed_a1,
  output logic [D*W-1:0] packed_a2,
  output logic [D*W-1:0] packed_a3,
  output logic           out_v
);

  localparam int unsigned L  = 3 * DILATION + 1;
  localparam int unsigned PW = $clog2(L);
  localparam int unsigned FW = $clog2(L + 1);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StTap0,
    StTap1,
    StTap2,
    StTap3,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [D*W-1:0]    vec_q, vec_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [D*W-1:0]    a0_q, a0_d, a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
  logic              out_v_q, out_v_d;
  logic              mem_we;
  logic [D*W-1:0]    mem [L];

  int unsigned       tap_off;
  logic [31:0]       ptr_ext;
  logic [PW-1:0]     rd_idx;
  logic [D*W-1:0]    rd_data;

  always_comb begin
    tap_off = 0;
    unique case (state_q)
      StTap0:  tap_off = 3 * DILATION;
      StTap1:  tap_off = 2 * DILATION;
      StTap2:  tap_off = DILATION;
      default: tap_off = 0;
    endcase
  end

  // Tap offset is always < L, so one conditional add of L implements the modulo-L wrap.
  always_comb begin
    ptr_ext = 32'(wr_ptr_q);
    if (ptr_ext >= tap_off) begin
      rd_idx = PW'(ptr_ext - tap_off);
    end else begin
      rd_idx = PW'(ptr_ext + L - tap_off);
    end
`ifdef ACTIVATION_CACHE_ZERO_PAD_EN
    rd_data = (32'(fill_q) <= tap_off) ? '0 : mem[rd_idx];
`else
    rd_data = mem[rd_idx];
`endif
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    a0_d     = a0_q;
    a1_d     = a1_q;
    a2_d     = a2_q;
    a3_d     = a3_q;
    out_v_d  = out_v_q;
    mem_we   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (inp_v) begin
          vec_d   = packed_inp;
          out_v_d = 1'b0;
          state_d = StWrite;
        end
      end
      StWrite: begin
        mem_we  = 1'b1;
        fill_d  = (fill_q == FW'(L)) ? fill_q : fill_q + FW'(1);
        state_d = StTap0;
      end
      StTap0: begin
        a0_d    = rd_data;
        state_d = StTap1;
      end
      StTap1: begin
        a1_d    = rd_data;
        state_d = StTap2;
      end
      StTap2: begin
        a2_d    = rd_data;
        state_d = StTap3;
      end
      StTap3: begin
        a3_d    = rd_data;
        state_d = StDone;
      end
      StDone: begin
        wr_ptr_d = (wr_ptr_q == PW'(L - 1)) ? '0 : wr_ptr_q + PW'(1);
`ifdef ACTIVATION_CACHE_ZERO_PAD_EN
        out_v_d  = 1'b1;
`else
        out_v_d  = (fill_q == FW'(L));
`endif
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      vec_q    <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      a0_q     <= '0;
      a1_q     <= '0;
      a2_q     <= '0;
      a3_q     <= '0;
      out_v_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      a0_q     <= a0_d;
      a1_q     <= a1_d;
      a2_q     <= a2_d;
      a3_q     <= a3_d;
      out_v_q  <= out_v_d;
    end
  end

  // Storage is deliberately not reset; fill tracks which slots are meaningful.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= vec_q;
    end
  end

  assign busy      = (state_q != StIdle);
  assign out_v     = out_v_q;
  assign packed_a0 = a0_q;
  assign packed_a1 = a1_q;
  assign packed_a2 = a2_q;
  assign packed_a3 = a3_q;

endmodule

// File: tb/tb_activation_cache.sv
// Directed bench for activation_cache at DILATION=2 (L=7); checks adapt to ACTIVATION_CACHE_ZERO_PAD_EN.
module tb_activation_cache;

  localparam int W   = 16;
  localparam int D   = 8;
  localparam int DIL = 2;
  localparam int DW  = D * W;
`ifdef ACTIVATION_CACHE_ZERO_PAD_EN
  localparam bit ZP = 1'b1;
`else
  localparam bit ZP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          inp_v = 1'b0;
  logic [DW-1:0] packed_inp = '0;
  logic          busy;
  logic [DW-1:0] packed_a0, packed_a1, packed_a2, packed_a3;
  logic          out_v;

  int tests = 0;
  int fails = 0;

  activation_cache #(
    .W       (W),
    .D       (D),
    .DILATION(DIL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inp_v     (inp_v),
    .packed_inp(packed_inp),
    .busy      (busy),
    .packed_a0 (packed_a0),
    .packed_a1 (packed_a1),
    .packed_a2 (packed_a2),
    .packed_a3 (packed_a3),
    .out_v     (out_v)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    int t0;
    int t1;
    int t2;
    int t3;
    bit ov;
  } vec_t;

  vec_t tbl[10];

  // Element e (element 0 in the MSBs) holds k*16+e so lane swaps are visible; k<=0 gives zero.
  function automatic logic [DW-1:0] mkvec(input int k);
    logic [DW-1:0] v;
    v = '0;
    if (k > 0) begin
      for (int e = 0; e < D; e++) v[(D-1-e)*W +: W] = W'(k * 16 + e);
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    inp_v = 1'b0;
    rst   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Returns #1 after edge N+6 (out_v/taps final).
  task automatic send(input logic [DW-1:0] v);
    @(negedge clk);
    inp_v      = 1'b1;
    packed_inp = v;
    @(posedge clk);
    #1;
    inp_v = 1'b0;
    check("busy_rise", busy, 1);
    check("out_v_clear", out_v, 0);
    repeat (5) @(posedge clk);
    #1;
    check("busy_n5", busy, 1);
    @(posedge clk);
    #1;
    check("busy_n6", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v1000;
    int bad;

    tbl[0] = '{1,  0, 0, 0, 1,  ZP};
    tbl[1] = '{2,  0, 0, 0, 2,  ZP};
    tbl[2] = '{3,  0, 0, 1, 3,  ZP};
    tbl[3] = '{4,  0, 0, 2, 4,  ZP};
    tbl[4] = '{5,  0, 1, 3, 5,  ZP};
    tbl[5] = '{6,  0, 2, 4, 6,  ZP};
    tbl[6] = '{7,  1, 3, 5, 7,  1'b1};
    tbl[7] = '{8,  2, 4, 6, 8,  1'b1};
    tbl[8] = '{9,  3, 5, 7, 9,  1'b1};
    tbl[9] = '{10, 4, 6, 8, 10, 1'b1};

    // Reset state
    do_reset();
    check("rst_out_v", out_v, 0);
    check("rst_busy", busy, 0);
    check("rst_a0", packed_a0, 0);
    check("rst_a1", packed_a1, 0);
    check("rst_a2", packed_a2, 0);
    check("rst_a3", packed_a3, 0);

    // Single vector of 0x1000 elements
    for (int e = 0; e < D; e++) v1000[e*W +: W] = 16'h1000;
    send(v1000);
    check("first_a3", packed_a3, v1000);
`ifdef ACTIVATION_CACHE_ZERO_PAD_EN
    check("first_out_v", out_v, 1);
    check("first_a2", packed_a2, 0);
    check("first_a1", packed_a1, 0);
    check("first_a0", packed_a0, 0);
`else
    check("first_out_v", out_v, 0);
`endif

    // Table: 10 vectors through L=7, wr_ptr wraps
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send(mkvec(tbl[i].val));
      check($sformatf("tbl%0d_out_v", i), out_v, tbl[i].ov);
      if (tbl[i].ov) begin
        check($sformatf("tbl%0d_a0", i), packed_a0, mkvec(tbl[i].t0));
        check($sformatf("tbl%0d_a1", i), packed_a1, mkvec(tbl[i].t1));
        check($sformatf("tbl%0d_a2", i), packed_a2, mkvec(tbl[i].t2));
        check($sformatf("tbl%0d_a3", i), packed_a3, mkvec(tbl[i].t3));
      end
    end

    // Hold for 50 idle cycles
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (out_v !== 1'b1 || busy !== 1'b0 || packed_a0 !== mkvec(4) || packed_a1 !== mkvec(6)
          || packed_a2 !== mkvec(8) || packed_a3 !== mkvec(10)) bad++;
    end
    check("hold_unstable_cycles", bad, 0);

    // Back-pressure: inp_v high for 20 edges, accepted at j = 0, 7, 14
    do_reset();
    bad = 0;
    @(negedge clk);
    inp_v      = 1'b1;
    packed_inp = mkvec(100);
    for (int j = 0; j < 20; j++) begin
      @(posedge clk);
      #1;
      if (busy !== ((j % 7) != 6)) bad++;
      packed_inp = mkvec(100 + j + 1);
    end
    inp_v = 1'b0;
    check("bp_busy_pattern_errs", bad, 0);
    @(posedge clk);
    #1;
    check("bp_busy_done", busy, 0);
    check("bp_a3", packed_a3, mkvec(114));
    check("bp_a2", packed_a2, mkvec(100));
`ifdef ACTIVATION_CACHE_ZERO_PAD_EN
    check("bp_out_v", out_v, 1);
    check("bp_a1", packed_a1, 0);
    check("bp_a0", packed_a0, 0);
`else
    check("bp_out_v", out_v, 0);
`endif

    // Reset during TAP2
    do_reset();
    send(mkvec(20));
    @(negedge clk);
    inp_v      = 1'b1;
    packed_inp = mkvec(21);
    @(posedge clk);
    #1;
    inp_v = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_v", out_v, 0);
    check("mid_rst_a2", packed_a2, 0);
    check("mid_rst_a3", packed_a3, 0);
    @(negedge clk);
    rst = 1'b1;
    send(mkvec(30));
    check("post_rst_a3", packed_a3, mkvec(30));
`ifdef ACTIVATION_CACHE_ZERO_PAD_EN
    check("post_rst_out_v", out_v, 1);
    check("post_rst_a2", packed_a2, 0);
    check("post_rst_a1", packed_a1, 0);
    check("post_rst_a0", packed_a0, 0);
`else
    check("post_rst_out_v", out_v, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/activation_cache.md
# activation_cache

Per-layer dilated causal activation buffer that feeds a `conv1d` stage. It accepts one packed D-element activation vector per timestep, which is either the network input or the previous layer's `packed_out`/`out_v`. It stores the vector in a circular buffer of depth 3·DILATION+1 and presents the four causal taps (t−3·DILATION, t−2·DILATION, t−DILATION, t) on `packed_a0`..`packed_a3`. One instance sits in front of each `conv1d`, with DILATION set per layer (1, 2, 4, …).

## Interface
Parameters:
- `W`, 16 — bits per element (signed fixed point, 4.12)
- `D`, 8 — elements per packed vector
- `DILATION`, 1 — tap spacing in timesteps; ≥1; buffer depth `L = 3*DILATION+1`

Ports:
- `clk`  in  1  — single clock; all logic on rising edge
- `rst`  in  1  — asynchronous, active-low reset
- `inp_v`  in  1  — new activation vector present on `packed_inp`
- `packed_inp`  in  D*W  — activation vector; element 0 in the MSBs
- `busy`  out  1  — high while a vector is being processed; `inp_v` is ignored while high
- `packed_a0`  out  D*W  — tap at t−3·DILATION (oldest, feeds k0)
- `packed_a1`  out  D*W  — tap at t−2·DILATION
- `packed_a2`  out  D*W  — tap at t−DILATION
- `packed_a3`  out  D*W  — tap at t (newest, feeds k3)
- `out_v`  out  1  — taps valid; level signal

## Operation
- Storage: `mem[0:L-1]` of D*W bits. Registers: `wr_ptr` (0..L−1) and `fill` (0..L, saturating).
- FSM states: IDLE, WRITE, TAP0, TAP1, TAP2, TAP3, DONE.
- IDLE: when `inp_v`=1, capture `packed_inp` and go to WRITE. `busy` rises and `out_v` clears.
- WRITE: `mem[wr_ptr] <= captured vector`; `fill <= min(fill+1, L)`; go to TAP0.
- TAPk (k = 0..3): let `off = (3−k)*DILATION`. Load `packed_ak <= mem[(wr_ptr − off) mod L]`. The subtraction wraps modulo L, never modulo 2^n. TAP3 reads the just-written slot (off = 0).
- DONE: `wr_ptr <= (wr_ptr == L−1) ? 0 : wr_ptr+1`; `out_v <= 1` (subject to Configuration); `busy <= 0`; return to IDLE.
- `out_v` and all `packed_a*` hold until the next accepted `inp_v`. A downstream `conv1d` can sample them at any point in that window.
- Data is stored verbatim. This block performs no arithmetic, clipping or relu on element values.
- `fill` counts vectors written since reset, including the current one.

## Timing
- `inp_v` sampled high in IDLE at edge N:
  - `busy` is high after edge N.
  - WRITE executes at N+1.
  - TAP0..TAP3 execute at N+2..N+5.
  - `out_v` is high and `busy` low after edge N+6.
- Latency is 6 cycles, input to taps. Maximum throughput is one vector per 7 cycles: the next `inp_v` is accepted at N+7.
- `inp_v` while `busy`=1 is dropped silently. It is not queued.
- `inp_v` at the same edge DONE completes is dropped, because the FSM is not yet in IDLE.
- Reset values: `out_v`=0, `busy`=0, `packed_a0..3`=0, `wr_ptr`=0, `fill`=0, state IDLE. `mem` is not cleared.
- Reset mid-operation aborts immediately. The partially processed vector counts as not written, even if WRITE already ran, because `fill` is cleared.

## Configuration
- Macro `ACTIVATION_CACHE_ZERO_PAD_EN` defined: causal zero padding.
  - In TAPk, if `fill ≤ off`, load `packed_ak` with 0 instead of memory. Stale or uninitialised `mem` is never exposed.
  - `out_v` asserts in DONE for every vector, including the first.
- Macro undefined: warm-up suppression.
  - Taps always read memory.
  - DONE asserts `out_v` only if `fill == L`. Otherwise `out_v` stays 0, and `busy` still drops so the next vector is accepted.
  - The first L−1 vectors after reset produce no `out_v`.

## Test plan
- Reset then single vector, ZERO_PAD_EN, DILATION=1: pulse `inp_v` with all elements 0x1000. Expect `out_v`=1 at N+6, `packed_a3`=all 0x1000, `packed_a0..a2`=0.
- Steady state, DILATION=2 (L=7), ZERO_PAD_EN: send vectors v1..v10 with all elements = index. After v10: a3=10, a2=8, a1=6, a0=4. `wr_ptr` wraps 6→0 without disturbing taps.
- Warm-up, macro undefined, DILATION=1 (L=4): vectors 1..3 give no `out_v`. Vector 4 gives `out_v`=1 with a0..a3 = 1, 2, 3, 4.
- Back-pressure: `inp_v` held high for 20 cycles. Exactly one vector is accepted per 7 cycles. `busy` waveform is 6 high / 1 low, and dropped inputs never appear on any tap.
- Reset mid-operation: assert `rst`=0 during TAP2. All outputs are 0 immediately. The next vector behaves as the first after reset, with a0..a2 = 0 under ZERO_PAD_EN.
- Hold: after `out_v`=1, leave `inp_v` low for 50 cycles. `out_v` and all taps remain stable.
